// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - MEM-stage load/store sequencer in front of the memory/serial controller
// Polls the serial status word before data-port accesses and returns a registered response.
module mem_access_sequencer #(
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
    parameter bit          BLOCKING_UART  = 1'b1,
    parameter int          POLL_LIMIT     = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        stall,
    output logic [1:0]  mc_mem_read,
    output logic [1:0]  mc_mem_write,
    output logic [15:0] mc_address,
    output logic [15:0] mc_data_in,
    input  logic [15:0] mc_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POLL   = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

    state_t      state, state_next;
    logic [1:0]  lat_rd, lat_wr;
    logic [15:0] lat_addr, lat_wdata;
    logic [15:0] poll_cnt;

    logic req_legal;
    logic req_blocking;
    logic port_ready;
    logic accept;

    assign req_legal    = (req_rd != 2'b00) ^ (req_wr != 2'b00);
    assign req_blocking = BLOCKING_UART && (req_addr == UART_DATA_ADDR);
    // Write waits for tx idle (bit0), read waits for rx data (bit1).
    assign port_ready   = (lat_wr != 2'b00) ? mc_data_out[0] : mc_data_out[1];
    assign accept       = (state == IDLE) && req_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        stall        = 1'b1;
        mc_mem_read  = 2'b00;
        mc_mem_write = 2'b00;
        mc_address   = 16'h0000;
        mc_data_in   = 16'h0000;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                stall     = 1'b0;
                if (req_valid) begin
                    if (!req_legal) begin
                        state_next = ERR;
                    end else if (req_blocking) begin
                        state_next = POLL;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            POLL: begin
                mc_mem_read = 2'b01;
                mc_address  = UART_STAT_ADDR;
                if (port_ready) begin
                    state_next = ACCESS;
                end else if (poll_cnt == POLL_LAST) begin
                    state_next = ERR;
                end
            end
            ACCESS: begin
                mc_mem_read  = lat_rd;
                mc_mem_write = lat_wr;
                mc_address   = lat_addr;
                mc_data_in   = (lat_wr != 2'b00) ? lat_wdata : 16'h0000;
                state_next   = IDLE;
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lat_rd     <= 2'b00;
            lat_wr     <= 2'b00;
            lat_addr   <= 16'h0000;
            lat_wdata  <= 16'h0000;
            poll_cnt   <= 16'h0000;
            resp_valid <= 1'b0;
            resp_rdata <= 16'h0000;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            if (accept) begin
                lat_rd    <= req_rd;
                lat_wr    <= req_wr;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                poll_cnt  <= 16'h0000;
            end
            if (state == POLL && !port_ready) begin
                poll_cnt <= poll_cnt + 16'h0001;
            end
            if (state == ACCESS) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_rdata <= (lat_rd != 2'b00) ? mc_data_out : 16'h0000;
            end
            if (state == ERR) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
                resp_rdata <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - directed self-checking bench for mem_access_sequencer
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_access_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_rd;
    logic [1:0]  req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic [1:0]  mc_mem_read;
    logic [1:0]  mc_mem_write;
    logic [15:0] mc_address;
    logic [15:0] mc_data_in;
    logic [15:0] mc_data_out;

    int checks = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    mem_access_sequencer #(
        .UART_DATA_ADDR(16'hBF00),
        .UART_STAT_ADDR(16'hBF01),
        .BLOCKING_UART (1'b1),
        .POLL_LIMIT    (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .stall       (stall),
        .mc_mem_read (mc_mem_read),
        .mc_mem_write(mc_mem_write),
        .mc_address  (mc_address),
        .mc_data_in  (mc_data_in),
        .mc_data_out (mc_data_out)
    );

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] rd, input logic [1:0] wr,
                             input logic [15:0] addr, input logic [15:0] wdata);
        req_valid = 1'b1;
        req_rd    = rd;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic clear_req();
        req_valid = 1'b0;
        req_rd    = 2'b00;
        req_wr    = 2'b00;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clear_req();
        mc_data_out = 16'h0000;
        #3;
        @(negedge CLK);
        checks++; if ({resp_valid, resp_err, resp_rdata} !== 18'h0)
            $display("FAIL reset_resp got v=%b e=%b d=%h exp 0/0/0000", resp_valid, resp_err, resp_rdata);
            else passed++;
        checks++; if ({mc_mem_read, mc_mem_write, mc_address, mc_data_in} !== 36'h0)
            $display("FAIL reset_mc got rd=%b wr=%b a=%h di=%h exp all 0", mc_mem_read, mc_mem_write, mc_address, mc_data_in);
            else passed++;
        checks++; if ({req_ready, stall} !== 2'b10)
            $display("FAIL reset_ready_stall got %b exp 10", {req_ready, stall});
            else passed++;
        next_cycle();
        RST = 1'b0;
        next_cycle();
    endtask

    task automatic test_ram_read(input logic [15:0] addr, input logic [15:0] data);
        drive_req(2'b01, 2'b00, addr, 16'h7777);
        mc_data_out = 16'h0000;
        @(negedge CLK);
        checks++; if ({req_ready, stall, mc_mem_read} !== 4'b1000)
            $display("FAIL rd_c0 got ready/stall/mrd=%b exp 1000", {req_ready, stall, mc_mem_read});
            else passed++;
        next_cycle();
        clear_req();
        mc_data_out = data;
        @(negedge CLK);
        checks++; if ({stall, mc_mem_read, mc_mem_write, mc_address, mc_data_in} !== {1'b1, 2'b01, 2'b00, addr, 16'h0000})
            $display("FAIL rd_c1 got st=%b rd=%b wr=%b a=%h di=%h exp 1/01/00/%h/0000", stall, mc_mem_read, mc_mem_write, mc_address, mc_data_in, addr);
            else passed++;
        checks++; if (resp_valid !== 1'b0)
            $display("FAIL rd_c1_valid got %b exp 0", resp_valid);
            else passed++;
        next_cycle();
        mc_data_out = 16'h1111;
        @(negedge CLK);
        checks++; if ({resp_valid, resp_err, resp_rdata, stall} !== {1'b1, 1'b0, data, 1'b0})
            $display("FAIL rd_c2_resp got v=%b e=%b d=%h st=%b exp 1/0/%h/0", resp_valid, resp_err, resp_rdata, stall, data);
            else passed++;
        next_cycle();
        @(negedge CLK);
        checks++; if (resp_valid !== 1'b0)
            $display("FAIL rd_c3_pulse got %b exp 0", resp_valid);
            else passed++;
        next_cycle();
    endtask

    task automatic test_ram_write();
        drive_req(2'b00, 2'b10, 16'h1234, 16'h5A5A);
        mc_data_out = 16'hFFFF;
        next_cycle();
        clear_req();
        @(negedge CLK);
        checks++; if ({mc_mem_read, mc_mem_write, mc_address, mc_data_in} !== {2'b00, 2'b10, 16'h1234, 16'h5A5A})
            $display("FAIL wr_c1 got rd=%b wr=%b a=%h di=%h exp 00/10/1234/5a5a", mc_mem_read, mc_mem_write, mc_address, mc_data_in);
            else passed++;
        next_cycle();
        @(negedge CLK);
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 16'h0000})
            $display("FAIL wr_c2_resp got v=%b e=%b d=%h exp 1/0/0000", resp_valid, resp_err, resp_rdata);
            else passed++;
        next_cycle();
    endtask

    task automatic test_uart_write();
        drive_req(2'b00, 2'b01, 16'hBF00, 16'h00A5);
        mc_data_out = 16'h0000;
        next_cycle();
        clear_req();
        for (int c = 1; c <= 4; c++) begin
            // bit1 set while not ready: only bit0 may gate a write
            mc_data_out = (c < 4) ? 16'hFFFE : 16'h0001;
            @(negedge CLK);
            checks++; if ({stall, mc_mem_read, mc_mem_write, mc_address} !== {1'b1, 2'b01, 2'b00, 16'hBF01})
                $display("FAIL uw_poll%0d got st=%b rd=%b wr=%b a=%h exp 1/01/00/bf01", c, stall, mc_mem_read, mc_mem_write, mc_address);
                else passed++;
            next_cycle();
        end
        mc_data_out = 16'h0000;
        @(negedge CLK);
        checks++; if ({mc_mem_read, mc_mem_write, mc_address, mc_data_in} !== {2'b00, 2'b01, 16'hBF00, 16'h00A5})
            $display("FAIL uw_access got rd=%b wr=%b a=%h di=%h exp 00/01/bf00/00a5", mc_mem_read, mc_mem_write, mc_address, mc_data_in);
            else passed++;
        checks++; if (resp_valid !== 1'b0)
            $display("FAIL uw_c5_valid got %b exp 0", resp_valid);
            else passed++;
        next_cycle();
        @(negedge CLK);
        checks++; if ({resp_valid, resp_err, resp_rdata, stall} !== {1'b1, 1'b0, 16'h0000, 1'b0})
            $display("FAIL uw_c6_resp got v=%b e=%b d=%h st=%b exp 1/0/0000/0", resp_valid, resp_err, resp_rdata, stall);
            else passed++;
        next_cycle();
    endtask

    task automatic test_uart_read_timeout();
        drive_req(2'b10, 2'b00, 16'hBF00, 16'h0000);
        mc_data_out = 16'hFFFD;
        next_cycle();
        clear_req();
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            checks++; if ({mc_mem_read, mc_address} !== {2'b01, 16'hBF01})
                $display("FAIL ut_poll%0d got rd=%b a=%h exp 01/bf01", c, mc_mem_read, mc_address);
                else passed++;
            next_cycle();
        end
        @(negedge CLK);
        checks++; if ({stall, mc_mem_read, mc_mem_write, mc_address, mc_data_in} !== {1'b1, 36'h0})
            $display("FAIL ut_err_state got st=%b rd=%b wr=%b a=%h di=%h exp 1/all 0", stall, mc_mem_read, mc_mem_write, mc_address, mc_data_in);
            else passed++;
        next_cycle();
        @(negedge CLK);
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b1, 16'h0000})
            $display("FAIL ut_resp got v=%b e=%b d=%h exp 1/1/0000", resp_valid, resp_err, resp_rdata);
            else passed++;
        checks++; if (mc_address !== 16'h0000)
            $display("FAIL ut_no_data_access got a=%h exp 0000", mc_address);
            else passed++;
        next_cycle();
    endtask

    task automatic test_illegal();
        drive_req(2'b01, 2'b01, 16'h0100, 16'h3333);
        mc_data_out = 16'hFFFF;
        next_cycle();
        clear_req();
        @(negedge CLK);
        checks++; if ({stall, mc_mem_read, mc_mem_write, mc_address, mc_data_in} !== {1'b1, 36'h0})
            $display("FAIL ill_c1 got st=%b rd=%b wr=%b a=%h di=%h exp 1/all 0", stall, mc_mem_read, mc_mem_write, mc_address, mc_data_in);
            else passed++;
        next_cycle();
        @(negedge CLK);
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b1, 16'h0000})
            $display("FAIL ill_c2_resp got v=%b e=%b d=%h exp 1/1/0000", resp_valid, resp_err, resp_rdata);
            else passed++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drive_req(2'b01, 2'b00, 16'h0200, 16'h0000);
        mc_data_out = 16'h0000;
        next_cycle();
        clear_req();
        mc_data_out = 16'hC0DE;
        next_cycle();
        // response cycle doubles as acceptance of a status-register write, which must not poll
        drive_req(2'b00, 2'b10, 16'hBF01, 16'h0042);
        mc_data_out = 16'h0000;
        @(negedge CLK);
        checks++; if ({resp_valid, resp_rdata, req_ready} !== {1'b1, 16'hC0DE, 1'b1})
            $display("FAIL b2b_c2 got v=%b d=%h rdy=%b exp 1/c0de/1", resp_valid, resp_rdata, req_ready);
            else passed++;
        next_cycle();
        clear_req();
        @(negedge CLK);
        checks++; if ({mc_mem_read, mc_mem_write, mc_address, mc_data_in} !== {2'b00, 2'b10, 16'hBF01, 16'h0042})
            $display("FAIL b2b_c3 got rd=%b wr=%b a=%h di=%h exp 00/10/bf01/0042", mc_mem_read, mc_mem_write, mc_address, mc_data_in);
            else passed++;
        next_cycle();
        @(negedge CLK);
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 16'h0000})
            $display("FAIL b2b_c4 got v=%b e=%b d=%h exp 1/0/0000", resp_valid, resp_err, resp_rdata);
            else passed++;
        next_cycle();
    endtask

    task automatic test_reset_mid_poll();
        drive_req(2'b01, 2'b00, 16'hBF00, 16'h0000);
        mc_data_out = 16'h0000;
        next_cycle();
        clear_req();
        next_cycle();
        RST = 1'b1;
        #1;
        checks++; if ({stall, mc_mem_read, mc_mem_write, mc_address, mc_data_in, resp_valid, resp_err, resp_rdata} !== 55'h0)
            $display("FAIL rst_poll_async got st=%b rd=%b wr=%b a=%h di=%h v=%b e=%b d=%h exp all 0",
                     stall, mc_mem_read, mc_mem_write, mc_address, mc_data_in, resp_valid, resp_err, resp_rdata);
            else passed++;
        next_cycle();
        RST = 1'b0;
        mc_data_out = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++; if ({resp_valid, stall} !== 2'b00)
                $display("FAIL rst_poll_quiet%0d got v/st=%b exp 00", c, {resp_valid, stall});
                else passed++;
            next_cycle();
        end
        test_ram_read(16'h0040, 16'hBEEF);
    endtask

    initial begin
        test_reset();
        test_ram_read(16'h0040, 16'hBEEF);
        test_ram_write();
        test_uart_write();
        test_uart_read_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_mid_poll();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Sits directly upstream of the memory/serial controller in the MEM stage of the 16-bit pipelined CPU. Accepts one load/store request at a time from the EX/MEM pipeline register and drives the controller's memRead/memWrite/address/dataIn. Captures the controller's dataOut and returns it with a registered response. For serial data-port accesses it first polls the serial status word until the port is ready, holding the pipeline stalled meanwhile.

Parameters:
UART_DATA_ADDR, 16'hBF00, serial data port address
UART_STAT_ADDR, 16'hBF01, serial status address; bit1 = rx data ready, bit0 = tx idle
BLOCKING_UART, 1, 1 = poll status before any UART_DATA_ADDR access; 0 = access directly
POLL_LIMIT, 1024, maximum status polls before timeout; legal range 1..65535

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_rd  in  2  read code: 00 none, 01/10 read
req_wr  in  2  write code: 00 none, 01/10 write
req_addr  in  16  access address
req_wdata  in  16  store data
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  16  load data; 0 for writes and errors
resp_err  out  1  qualifies resp_valid: illegal code or poll timeout
stall  out  1  hold upstream pipeline
mc_mem_read  out  2  to controller memRead
mc_mem_write  out  2  to controller memWrite
mc_address  out  16  to controller address
mc_data_in  out  16  to controller dataIn
mc_data_out  in  16  from controller dataOut

Behaviour:
- One clock, CLK. RST is asynchronous and active-high.
- Reset state: state IDLE, poll counter 0, latched request cleared, resp_valid 0, resp_rdata 0, resp_err 0.
- mc_* outputs are decoded combinationally from state and latched registers. In IDLE they are all 0, so during reset mc_* are also all 0.
- States: IDLE, POLL, ACCESS, ERR.
- IDLE:
  - req_ready = 1, stall = 0.
  - A request is accepted when req_valid = 1.
  - On acceptance, latch rd, wr, addr and wdata.
  - A request is legal when exactly one of req_rd or req_wr is nonzero.
  - Illegal request -> ERR.
  - Legal, addr == UART_DATA_ADDR and BLOCKING_UART = 1 -> POLL, counter cleared.
  - Any other legal request -> ACCESS.
- POLL:
  - Drive mc_mem_read = 01, mc_mem_write = 00, mc_address = UART_STAT_ADDR.
  - Sample mc_data_out at the clock edge.
  - Ready condition: bit0 for a write, bit1 for a read.
  - Ready -> ACCESS.
  - Not ready and counter == POLL_LIMIT-1 -> ERR.
  - Otherwise increment the counter and stay in POLL.
- ACCESS:
  - Drive the latched rd/wr codes, address and wdata. mc_data_in is 0 for reads.
  - At the clock edge, resp_rdata <= mc_data_out for a read, 0 for a write.
  - Then resp_valid <= 1, resp_err <= 0, and go to IDLE.
- ERR:
  - mc_* are all 0.
  - At the clock edge: resp_valid <= 1, resp_err <= 1, resp_rdata <= 0, go to IDLE.
- resp_valid is high for exactly one cycle, the first IDLE cycle after ACCESS/ERR. A new request may be accepted in that same cycle.
- stall = (state != IDLE).
- Latency:
  - Normal access: accept in cycle 0, ACCESS in cycle 1, resp_valid in cycle 2. Throughput is one access per 2 cycles.
  - Blocking UART access with N not-ready polls: resp_valid in cycle N+3.
- Writes to UART_STAT_ADDR, and all accesses with BLOCKING_UART = 0, go straight to ACCESS with no polling.
- Request inputs are ignored outside IDLE.
- RST asserted mid-POLL or mid-ACCESS aborts the operation immediately. No response is produced and mc_* return to 0.

Test Plan:
- RAM read: req_rd=01, addr=16'h0040, mc_data_out=16'hBEEF -> mc_mem_read=01 in cycle 1; resp_valid=1, resp_rdata=16'hBEEF, resp_err=0 in cycle 2; stall high only in cycle 1.
- RAM write: req_wr=10, addr=16'h1234, wdata=16'h5A5A -> cycle 1 drives mc_mem_write=10, mc_address=16'h1234, mc_data_in=16'h5A5A; resp_rdata=0 in cycle 2.
- UART write: addr=BF00, status bit0 = 0 for 3 polls then 1 -> 4 cycles with mc_address=BF01 read; ACCESS writes BF00; resp_valid in cycle 6.
- UART read timeout: POLL_LIMIT=4, bit1 stuck 0 -> exactly 4 polls, then resp_valid=1, resp_err=1, resp_rdata=0; no BF00 access is issued.
- Illegal code: req_rd=01 and req_wr=01 together -> no mc_* activity; resp_err=1 pulse in cycle 2.
- Reset mid-poll: assert RST during the 2nd poll -> all outputs 0 immediately, no resp_valid; a fresh RAM read after reset completes normally.
